// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the 32-bit to 16-bit async SRAM bridge.
package sram_controller_pkg;

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} sram_state_t;

    localparam int          SRAM_ADDR_W         = 18;
    localparam int          SRAM_DATA_W         = 16;
    localparam int          WORD_IDX_W          = SRAM_ADDR_W - 1;
    localparam logic [31:0] DEFAULT_ADDR_BASE   = 32'd1024;
    localparam int          DEFAULT_HALF_CYCLES = 3;

endpackage

// File: rtl/sram_controller_if.sv
// MEM-stage data-memory request/response bundle.
interface sram_controller_if;

    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (output wr_en, rd_en, address, write_data, input read_data, ready);
    modport slave  (input wr_en, rd_en, address, write_data, output read_data, ready);

endinterface

// File: rtl/sram_wait_counter.sv
// Loadable down-counter; done is high while the count sits at zero.
module sram_wait_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (en && count != '0)
            count <= count - W'(1);
    end

    assign done = (count == '0);

endmodule

// File: rtl/sram_controller.sv
// Bridges a 32-bit word access onto two half-word cycles of a 16-bit async SRAM,
// freezing the pipeline (ready=0) while the access is in flight.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = DEFAULT_ADDR_BASE,
    parameter int          HALF_CYCLES = DEFAULT_HALF_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    sram_controller_if.slave       mem,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_OE_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N
);

    localparam int             CNT_W    = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HALF_CYCLES - 1);

    sram_state_t state, state_n;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic        is_wr_q;
    logic        req, ready, latch;
    logic        cnt_load, cnt_en, cnt_done;
    logic        cap_lo, cap_hi, dq_oe;
    logic [SRAM_DATA_W-1:0] dq_out;
    logic [31:0]            word_off;
    logic [WORD_IDX_W-1:0]  word_idx;
    logic                   unused_word_off;

    assign req = mem.wr_en | mem.rd_en;

    // Out-of-range addresses wrap silently into the 17-bit word space.
    assign word_off        = (addr_q - ADDR_BASE) >> 2;
    assign word_idx        = word_off[WORD_IDX_W-1:0];
    assign unused_word_off = ^word_off[31:WORD_IDX_W];

    sram_wait_counter #(.W(CNT_W)) u_wait (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (CNT_LOAD),
        .done     (cnt_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            is_wr_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state <= state_n;
            if (latch) begin
                addr_q  <= mem.address;
                wdata_q <= mem.write_data;
                is_wr_q <= mem.wr_en;
            end
            if (cap_lo) rdata_q[15:0]  <= SRAM_DQ;
            if (cap_hi) rdata_q[31:16] <= SRAM_DQ;
        end
    end

    always_comb begin
        state_n   = state;
        ready     = 1'b0;
        latch     = 1'b0;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        cap_lo    = 1'b0;
        cap_hi    = 1'b0;
        dq_oe     = 1'b0;
        dq_out    = '0;
        SRAM_ADDR = '0;
        SRAM_WE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        case (state)
            IDLE: begin
                ready = ~req;
                if (req) begin
                    latch    = 1'b1;
                    cnt_load = 1'b1;
                    state_n  = LO;
                end
            end
            LO, HI: begin
                SRAM_ADDR = {word_idx, state == HI};
                if (is_wr_q) begin
                    dq_oe     = 1'b1;
                    dq_out    = (state == HI) ? wdata_q[31:16] : wdata_q[15:0];
                    // WE rises on the last cycle so the SRAM latches stable address/data.
                    SRAM_WE_N = cnt_done;
                end else begin
                    SRAM_OE_N = 1'b0;
                end
                if (cnt_done) begin
                    if (state == LO) begin
                        cap_lo   = ~is_wr_q;
                        cnt_load = 1'b1;
                        state_n  = HI;
                    end else begin
                        cap_hi  = ~is_wr_q;
                        state_n = DONE;
                    end
                end else begin
                    cnt_en = 1'b1;
                end
            end
            DONE: begin
                ready   = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign SRAM_DQ       = dq_oe ? dq_out : 'z;
    assign SRAM_CE_N     = 1'b0;
    assign SRAM_UB_N     = 1'b0;
    assign SRAM_LB_N     = 1'b0;
    assign mem.ready     = ready;
    assign mem.read_data = rdata_q;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: pin-level async SRAM model, vector table, corner sequences
// and random traffic checked against a word-level memory model.
module tb_sram_controller;

    localparam logic [31:0] BASE    = 32'd1024;
    localparam int          HC      = 3;
    localparam int          LAT     = 2 * HC + 1;
    localparam int          TIMEOUT = 40;

    logic        clk = 1'b0;
    logic        rst;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        we_n, oe_n, ce_n, ub_n, lb_n;

    sram_controller_if mem_bus();

    sram_controller #(.ADDR_BASE(BASE), .HALF_CYCLES(HC)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem       (mem_bus),
        .SRAM_DQ   (sram_dq),
        .SRAM_ADDR (sram_addr),
        .SRAM_WE_N (we_n),
        .SRAM_OE_N (oe_n),
        .SRAM_CE_N (ce_n),
        .SRAM_UB_N (ub_n),
        .SRAM_LB_N (lb_n)
    );

    always #5 clk = ~clk;

    // Pin-level SRAM; probe_en pulls the bus to 0 so any DUT drive shows up.
    logic [15:0] sram_mem [0:262143];
    logic        probe_en  = 1'b0;
    logic        poke_en   = 1'b0;
    logic [17:0] poke_addr = '0;
    logic [15:0] poke_val  = '0;

    assign sram_dq = (!oe_n && we_n && !ce_n) ? sram_mem[sram_addr]
                   : (probe_en ? 16'h0000 : 16'hzzzz);

    always @(negedge clk) begin
        if (poke_en)
            sram_mem[poke_addr] <= poke_val;
        else if (!we_n && !ce_n)
            sram_mem[sram_addr] <= sram_dq;
    end

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] ref_word [int unsigned];
    logic [31:0] last_rd;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [17:0] exp_a0;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [17:0] a, input logic [15:0] v);
        @(posedge clk); #1;
        poke_addr = a;
        poke_val  = v;
        poke_en   = 1'b1;
        @(posedge clk); #1;
        poke_en   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            mem_bus.wr_en = 1'b0;
            mem_bus.rd_en = 1'b0;
        end
    endtask

    task automatic bus_probe(input string name);
        probe_en = 1'b1;
        #1;
        check(name, 32'(sram_dq), 32'h0);
        probe_en = 1'b0;
    endtask

    // One access, request held until ready; cycle 0 is the request cycle.
    task automatic run_and_check(input string tag, input logic w, input logic r,
                                 input logic [31:0] a, input logic [31:0] d,
                                 input logic [31:0] exp_rd, input logic [17:0] exp_a0);
        int          lat = -1;
        int          we_lo = 0, we_rise = 0, oe_lo = 0;
        logic        prev_we = 1'b1;
        logic [17:0] a0 = '0, a1 = '0;
        logic        is_w;
        @(posedge clk); #1;
        mem_bus.wr_en      = w;
        mem_bus.rd_en      = r;
        mem_bus.address    = a;
        mem_bus.write_data = d;
        for (int k = 0; k <= TIMEOUT; k++) begin
            @(negedge clk);
            if (!we_n) we_lo++;
            if (!prev_we && we_n) we_rise++;
            prev_we = we_n;
            if (!oe_n) oe_lo++;
            if (k == 1)      a0 = sram_addr;
            if (k == HC + 1) a1 = sram_addr;
            if (mem_bus.ready) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
        end
        is_w = w;
        check({tag, ".latency"}, 32'(lat), 32'(LAT));
        check({tag, ".we_low_cycles"}, 32'(we_lo), is_w ? 32'(2 * (HC - 1)) : 32'h0);
        check({tag, ".we_pulses"}, 32'(we_rise), is_w ? 32'd2 : 32'd0);
        check({tag, ".oe_low_cycles"}, 32'(oe_lo), is_w ? 32'h0 : 32'(2 * HC));
        check({tag, ".addr_lo"}, 32'(a0), 32'(exp_a0));
        check({tag, ".addr_hi"}, 32'(a1), 32'(exp_a0 | 18'd1));
        check({tag, ".read_data"}, mem_bus.read_data, exp_rd);
        if (is_w) begin
            check({tag, ".sram_lo"}, 32'(sram_mem[exp_a0]), 32'(d[15:0]));
            check({tag, ".sram_hi"}, 32'(sram_mem[exp_a0 | 18'd1]), 32'(d[31:16]));
        end
    endtask

    initial begin
        rst                = 1'b0;
        mem_bus.wr_en      = 1'b0;
        mem_bus.rd_en      = 1'b0;
        mem_bus.address    = '0;
        mem_bus.write_data = '0;

        // Reset values
        #2;
        check("rst.ready", 32'(mem_bus.ready), 32'h1);
        check("rst.we_n", 32'(we_n), 32'h1);
        check("rst.oe_n", 32'(oe_n), 32'h1);
        check("rst.ce_ub_lb", 32'({ce_n, ub_n, lb_n}), 32'h0);
        check("rst.sram_addr", 32'(sram_addr), 32'h0);
        check("rst.read_data", mem_bus.read_data, 32'h0);
        bus_probe("rst.dq_released");
        @(negedge clk);
        rst = 1'b1;

        poke(18'd2, 16'h5678);
        poke(18'd3, 16'h1234);
        ref_word[1] = 32'h1234_5678;

        // Back-to-back vectors: each request starts the cycle after the previous DONE.
        tbl[0] = '{1'b1, 1'b0, 32'd1024, 32'hDEAD_BEEF, 32'h0000_0000, 18'd0};
        tbl[1] = '{1'b0, 1'b1, 32'd1028, 32'h0000_0000, 32'h1234_5678, 18'd2};
        tbl[2] = '{1'b1, 1'b1, 32'd1032, 32'hA5A5_A5A5, 32'h1234_5678, 18'd4};
        tbl[3] = '{1'b1, 1'b0, 32'd1036, 32'h1111_2222, 32'h1234_5678, 18'd6};
        tbl[4] = '{1'b0, 1'b1, 32'd1036, 32'h0000_0000, 32'h1111_2222, 18'd6};
        tbl[5] = '{1'b1, 1'b0, 32'd1024 + 32'h0008_0000, 32'h0BAD_F00D, 32'h1111_2222, 18'd0};
        tbl[6] = '{1'b0, 1'b1, 32'd1027, 32'h0000_0000, 32'h0BAD_F00D, 18'd0};
        for (int i = 0; i < 7; i++) begin
            run_and_check($sformatf("vec%0d", i), tbl[i].wr, tbl[i].rd, tbl[i].addr,
                          tbl[i].wdata, tbl[i].exp_rd, tbl[i].exp_a0);
            if (tbl[i].wr) ref_word[32'(tbl[i].exp_a0 >> 1)] = tbl[i].wdata;
        end
        last_rd = 32'h0BAD_F00D;

        // Nothing restarts once requests drop
        begin
            int busy = 0, wes = 0;
            idle(1);
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (!mem_bus.ready) busy++;
                if (!we_n) wes++;
            end
            check("quiet.busy_cycles", 32'(busy), 32'h0);
            check("quiet.we_cycles", 32'(wes), 32'h0);
        end

        // Reset in the last LO cycle of a write
        poke(18'd20, 16'h0000);
        poke(18'd21, 16'h7777);
        @(posedge clk); #1;
        mem_bus.wr_en      = 1'b1;
        mem_bus.address    = BASE + 32'd40;
        mem_bus.write_data = 32'hCAFE_F00D;
        repeat (HC) @(posedge clk);
        #1;
        check("abort.busy_before", 32'(mem_bus.ready), 32'h0);
        rst           = 1'b0;
        mem_bus.wr_en = 1'b0;
        #1;
        check("abort.we_n", 32'(we_n), 32'h1);
        check("abort.oe_n", 32'(oe_n), 32'h1);
        check("abort.ready", 32'(mem_bus.ready), 32'h1);
        check("abort.sram_addr", 32'(sram_addr), 32'h0);
        check("abort.read_data", mem_bus.read_data, 32'h0);
        bus_probe("abort.dq_released");
        @(negedge clk);
        rst = 1'b1;
        check("abort.sram_lo_written", 32'(sram_mem[20]), 32'h0000_F00D);
        check("abort.sram_hi_kept", 32'(sram_mem[21]), 32'h0000_7777);
        ref_word[10] = 32'h7777_F00D;
        run_and_check("abort.readback", 1'b0, 1'b1, BASE + 32'd40, 32'h0, 32'h7777_F00D, 18'd20);
        last_rd = 32'h7777_F00D;

        // Random traffic against the word-level model
        for (int i = 0; i < 40; i++) begin
            int unsigned w;
            logic        do_w, do_r;
            logic [31:0] a, d;
            w    = $urandom_range(0, 63);
            d    = $urandom;
            do_w = ($urandom_range(0, 1) == 1) || !ref_word.exists(w);
            do_r = do_w ? ($urandom_range(0, 7) == 0) : 1'b1;
            a    = BASE + 32'(w) * 4 + 32'($urandom_range(0, 3))
                 + (($urandom_range(0, 3) == 0) ? 32'h0008_0000 : 32'h0);
            if (do_w) ref_word[w] = d;
            else      last_rd = ref_word[w];
            if ($urandom_range(0, 1) == 1) idle(1);
            run_and_check($sformatf("rnd%0d", i), do_w, do_r, a, d, last_rd, {w[16:0], 1'b0});
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Multi-cycle bridge between the MEM stage's 32-bit data-memory request and an external 16-bit asynchronous SRAM (256K x 16).
- Splits each word access into two half-word SRAM cycles.
- Deasserts ready while busy; the pipeline uses the inverse of ready as a global freeze for IF/ID/EXE/MEM registers.
- Sits directly downstream of MEM stage and replaces the internal data-memory array.

Parameters:
- ADDR_BASE, 1024, byte address mapped to SRAM word 0.
- HALF_CYCLES, 3, clock cycles each 16-bit SRAM access is held (≥1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- wr_en  in  1  store request from MEM stage (level, held until ready)
- rd_en  in  1  load request from MEM stage (level, held until ready)
- address  in  32  byte address (ALU result)
- write_data  in  32  store data (Rm value)
- read_data  out  32  load result, valid when ready=1 after a read
- ready  out  1  1 = no access in flight / access complete; 0 = freeze pipeline
- SRAM_DQ  inout  16  SRAM data bus
- SRAM_ADDR  out  18  SRAM half-word address
- SRAM_WE_N  out  1  write enable, active-low
- SRAM_OE_N  out  1  output enable, active-low
- SRAM_CE_N  out  1  chip enable, active-low (tied 0)
- SRAM_UB_N  out  1  upper byte enable (tied 0)
- SRAM_LB_N  out  1  lower byte enable (tied 0)

Behaviour:
- Reset: one clock, asynchronous, active-low. Reset value of every output:
  - state=IDLE, counter=0, read_data=0, latched address/data=0
  - SRAM_WE_N=1, SRAM_OE_N=1, SRAM_ADDR=0, SRAM_DQ=high-Z
  - ready=1
- Reset asserted mid-access: aborts immediately to the reset values above; a half-completed write may leave one half written.
- FSM states: IDLE, LO, HI, DONE.
  - IDLE: if wr_en|rd_en, latch address, write_data and op (write has priority if both asserted), clear counter, go to LO. ready = ~(wr_en|rd_en) combinationally, so the freeze starts in the request cycle.
  - LO: SRAM_ADDR = {word_idx,1'b0}. Count HALF_CYCLES cycles, then go to HI.
  - HI: SRAM_ADDR = {word_idx,1'b1}. Count HALF_CYCLES cycles, then go to DONE.
  - DONE: ready=1 for exactly one cycle, read_data stable; go unconditionally to IDLE. A request still high in DONE is not restarted; the pipeline advances on this edge.
- Outside DONE and idle-without-request, ready=0.
- word_idx = (address - ADDR_BASE) >> 2, truncated to 17 bits; out-of-range addresses wrap silently. Bits [1:0] are ignored (word accesses only).
- Write:
  - DQ drives write_data[15:0] in LO and write_data[31:16] in HI.
  - SRAM_WE_N=0 in every cycle of LO/HI except the last cycle of each, giving a WE high edge while address/data are stable.
  - SRAM_OE_N=1 throughout.
- Read:
  - DQ high-Z; SRAM_OE_N=0 in LO/HI.
  - read_data[15:0] registered from DQ on the final LO cycle; read_data[31:16] on the final HI cycle.
  - read_data holds its value until the next read completes.
- DQ is driven only during write LO/HI; high-Z in all other states.
- Latency: request at cycle 0 → ready=1 at cycle 2*HALF_CYCLES+1 (7 with defaults); ready low for 2*HALF_CYCLES+1 cycles.
- Back-to-back requests: a new request in the cycle after DONE starts a fresh access (ready drops again).

Decomposition:
- Shared package holds:
  - state enum {IDLE,LO,HI,DONE}
  - SRAM_ADDR_W=18, SRAM_DATA_W=16
  - default ADDR_BASE
- One natural sub-module, sram_wait_counter: loadable down-counter with a done flag, reused by a later cache controller.
- FSM and datapath stay in sram_controller.

Test Plan:
- Reset low mid-write (cycle 3) → next cycle SRAM_WE_N=1, DQ=Z, ready=1, state IDLE; bench SRAM model shows low half written, high half unchanged.
- Write 0xDEADBEEF at address 1024 → SRAM[0]=0xBEEF, SRAM[1]=0xDEAD; ready low cycles 0–6, high at cycle 7; WE_N pulses low twice, each 2 cycles.
- Read at address 1028 with SRAM[2]=0x5678, SRAM[3]=0x1234 → read_data=0x12345678 when ready=1 at cycle 7; OE_N=0 during LO/HI; DQ never driven by the DUT.
- rd_en and wr_en both asserted with write_data=0xA5A5A5A5 at address 1032 → write performed (SRAM[4]=SRAM[5]=0xA5A5), read_data unchanged.
- Back-to-back: write 0x11112222 at 1036, then read 1036 in the cycle after DONE → read returns 0x11112222 after a further 7 cycles; no request is dropped or duplicated.
- Address 1024+4*2^17 → SRAM_ADDR wraps to 0/1.
